// File: rtl/ff_stim_gen.sv
// Stimulus source for the ff_replicator pipeline: programmable burst on din/ce, then STAGES flush strobes.
// Latency: busy rises one cycle after start; first strobe ce_div+1 cycles later; done one cycle after last flush strobe.
// No backpressure: strobes are free-running at the latched pace; start is ignored while a sequence is active.
module ff_stim_gen #(
  parameter int               WIDTH     = 10,
  parameter int               STAGES    = 10,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 10'h240,
  parameter logic [WIDTH-1:0] LFSR_SEED = 10'h001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [3:0]       ce_div,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] din,
  output logic             ce,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGES - 1);

  // Alternating pattern seed: bit0 set, every other bit above it set.
  function automatic logic [WIDTH-1:0] alt_first();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) w[i] = (i % 2 == 0);
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] first_word(input logic [1:0] m);
    case (m)
      2'd0:    return '0;
      2'd1:    return WIDTH'(1);
      2'd2:    return LFSR_SEED;
      default: return alt_first();
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m, input logic [WIDTH-1:0] p);
    case (m)
      2'd0:    return p + WIDTH'(1);
      2'd1:    return {p[WIDTH-2:0], p[WIDTH-1]};
      2'd2:    return {p[WIDTH-2:0], ^(p & LFSR_TAPS)};
      default: return ~p;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       cdiv_q, cdiv_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [3:0]       div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             ce_q, ce_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             strobe;
  logic             burst_last;

  assign strobe     = (div_q == cdiv_q);
  // Widened compare so a burst_len of all-ones never wraps the counter first.
  assign burst_last = (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, len_q});

  // Next-state and registered-output decode for the sequencer.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cdiv_d  = cdiv_q;
    len_d   = len_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    din_d   = din_q;
    ce_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle is still the tail of the previous sequence.
        if (start && !done_q) begin
          mode_d  = mode;
          cdiv_d  = ce_div;
          len_d   = burst_len;
          div_d   = '0;
          cnt_d   = '0;
          pat_d   = first_word(mode);
          busy_d  = 1'b1;
          state_d = (burst_len != '0) ? RUN : FLUSH;
        end
      end
      RUN: begin
        if (strobe) begin
          ce_d  = 1'b1;
          div_d = '0;
          din_d = pat_q;
          pat_d = next_word(mode_q, pat_q);
          if (burst_last) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      FLUSH: begin
        if (strobe) begin
          ce_d  = 1'b1;
          div_d = '0;
          din_d = '0;
          if (cnt_q == STG_LAST) begin
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cdiv_q  <= '0;
      len_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      din_q   <= '0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cdiv_q  <= cdiv_d;
      len_q   <= len_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      din_q   <= din_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign din  = din_q;
  assign ce   = ce_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ff_stim_gen.sv
// Bench for ff_stim_gen: table-driven sequences, random sequences, hand-written corner cases.
module tb_ff_stim_gen;

  localparam int S = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  ce_div;
  logic [15:0] burst_len;
  logic [9:0]  din;
  logic        ce;
  logic        busy;
  logic        done;

  int vec = 0;
  int miscompares = 0;
  logic [9:0] cap[$];

  ff_stim_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ce_div(ce_div),
    .burst_len(burst_len), .din(din), .ce(ce), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         m;
    int         d;
    int         b;
    logic [9:0] exp_first;
    logic [9:0] exp_last;
    int         exp_len;
  } vec_t;

  task automatic chk(input string nm, input int t, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, got, exp);
    end
  endtask

  // Burst words derived directly from the pattern definitions.
  task automatic gen_words(input int m, input int b, output logic [9:0] w[$]);
    logic [9:0] l;
    w.delete();
    l = 10'h001;
    for (int k = 0; k < b; k++) begin
      case (m)
        0: w.push_back(10'(k % 1024));
        1: w.push_back(10'(1) << (k % 10));
        2: begin w.push_back(l); l = {l[8:0], l[9] ^ l[6]}; end
        default: w.push_back((k % 2 == 0) ? 10'h155 : 10'h2AA);
      endcase
    end
  endtask

  // Launch one sequence and check every cycle from busy rising until after done.
  task automatic run_seq(input string nm, input int m, input int d, input int b, input int poke,
                         input bit has_exp, input logic [9:0] ef, input logic [9:0] el, input int elen);
    logic [9:0] w[$];
    int n, k, tdone;
    logic [9:0] exp_din;
    gen_words(m, b, w);
    cap.delete();
    n = (b + S) * (d + 1);
    tdone = -1;
    mode = 2'(m); ce_div = 4'(d); burst_len = 16'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t <= n + 2; t++) begin
      k = (t > n) ? (b + S) : t / (d + 1);
      exp_din = (k == 0 || k > b) ? 10'h000 : w[k-1];
      chk({nm, ".ce"},   t, 32'(ce),   32'(t > 0 && t <= n && (t % (d + 1)) == 0));
      chk({nm, ".din"},  t, 32'(din),  32'(exp_din));
      chk({nm, ".busy"}, t, 32'(busy), 32'(t <= n));
      chk({nm, ".done"}, t, 32'(done), 32'(t == n + 1));
      if (ce) cap.push_back(din);
      if (done && tdone < 0) tdone = t;
      if (t == poke) begin
        start = 1'b1; mode = 2'($urandom_range(0, 3));
        ce_div = 4'($urandom_range(0, 15)); burst_len = 16'($urandom_range(0, 50));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, ".nstrobes"}, n, 32'(cap.size()), 32'(b + S));
    chk({nm, ".len"}, n, 32'(tdone), 32'(elen));
    if (has_exp && b > 0 && cap.size() >= b) begin
      chk({nm, ".first"}, 0, 32'(cap[0]), 32'(ef));
      chk({nm, ".last"}, b, 32'(cap[b-1]), 32'(el));
    end
  endtask

  vec_t tbl[6];

  initial begin
    int m, d, b, n, bad;
    bit seen[int];

    tbl[0] = '{"cnt_contig", 0, 0, 4,  10'h000, 10'h003, 15};
    tbl[1] = '{"walk_paced", 1, 2, 12, 10'h001, 10'h002, 67};
    tbl[2] = '{"alt_div1",   3, 1, 5,  10'h155, 10'h155, 31};
    tbl[3] = '{"lfsr_short", 2, 0, 3,  10'h001, 10'h004, 14};
    tbl[4] = '{"cnt_div15",  0, 15, 2, 10'h000, 10'h001, 193};
    tbl[5] = '{"empty",      0, 0, 0,  10'h000, 10'h000, 11};

    rst = 1'b1; start = 1'b0; mode = '0; ce_div = '0; burst_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.din", 0, 32'(din), 0);
    chk("reset.ce", 0, 32'(ce), 0);
    chk("reset.busy", 0, 32'(busy), 0);
    chk("reset.done", 0, 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_seq(tbl[i].name, tbl[i].m, tbl[i].d, tbl[i].b, -1, 1'b1,
              tbl[i].exp_first, tbl[i].exp_last, tbl[i].exp_len);

    // Empty burst with start pulsed during FLUSH.
    run_seq("empty_poke", 2, 0, 0, 4, 1'b0, 10'h0, 10'h0, 11);
    // Back-to-back restart with start raised during RUN.
    run_seq("walk_poke", 1, 1, 6, 3, 1'b1, 10'h001, 10'h020, 33);

    // LFSR full period.
    run_seq("lfsr_full", 2, 0, 1024, -1, 1'b0, 10'h0, 10'h0, 1035);
    bad = 0;
    for (int i = 0; i < 1023 && i < cap.size(); i++) begin
      if (cap[i] == 10'h000 || seen.exists(int'(cap[i]))) bad++;
      seen[int'(cap[i])] = 1'b1;
    end
    chk("lfsr.distinct", 0, 32'(bad), 0);
    chk("lfsr.word1024", 1024, 32'((cap.size() > 1023) ? cap[1023] : 10'h3FF), 32'h001);

    // Randomized sequences.
    for (int r = 0; r < 10; r++) begin
      m = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      b = $urandom_range(0, 20);
      n = (b + S) * (d + 1);
      run_seq("rand", m, d, b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1,
              1'b0, 10'h0, 10'h0, n + 1);
    end

    // Reset on the third strobe of an alternating burst.
    mode = 2'd3; ce_div = 4'd0; burst_len = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstmid.ce3", 3, 32'(ce), 1);
    chk("rstmid.din3", 3, 32'(din), 32'h155);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid.din", 4, 32'(din), 0);
    chk("rstmid.ce", 4, 32'(ce), 0);
    chk("rstmid.busy", 4, 32'(busy), 0);
    chk("rstmid.done", 4, 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid.nodone", 5 + i, 32'({busy, done}), 0);
    end
    run_seq("rst_restart", 3, 0, 2, -1, 1'b1, 10'h155, 10'h2AA, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
